// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: one request at a time, a fixed
// access latency, and little-endian byte/halfword/word accesses on a byte-addressed RAM.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [2:0]              lat_funct3;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic [7:0]              ram [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0]   addr1, addr2, addr3;
    logic [7:0]              byte0, byte1, byte2, byte3;
    logic                    bad;
    logic                    commit;
    logic [31:0]             load_data;

    // Byte lanes wrap modulo the RAM size because the sums are ADDR_WIDTH wide.
    assign addr1 = lat_addr + ADDR_WIDTH'(1);
    assign addr2 = lat_addr + ADDR_WIDTH'(2);
    assign addr3 = lat_addr + ADDR_WIDTH'(3);
    assign byte0 = ram[lat_addr];
    assign byte1 = ram[addr1];
    assign byte2 = ram[addr2];
    assign byte3 = ram[addr3];

    // The access takes effect on the first cycle in RESP, the edge where resp_valid rises.
    assign commit = (state == RESP) && !resp_valid;

    always_comb begin
        bad = 1'b1;
        case (lat_funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lat_addr[0];
            3'b010:  bad = |lat_addr[1:0];
            3'b100:  bad = lat_we;
            3'b101:  bad = lat_we | lat_addr[0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (lat_funct3)
            3'b000:  load_data = {{24{byte0[7]}}, byte0};
            3'b001:  load_data = {{16{byte1[7]}}, byte1, byte0};
            3'b010:  load_data = {byte3, byte2, byte1, byte0};
            3'b100:  load_data = {24'h0, byte0};
            3'b101:  load_data = {16'h0, byte1, byte0};
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr[ADDR_WIDTH-1:0];
                        lat_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'h0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= bad;
                        resp_rdata <= (bad || lat_we) ? 32'h0 : load_data;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && lat_we && !bad) begin
            ram[lat_addr] <= lat_wdata[7:0];
            if (lat_funct3[1:0] != 2'b00) begin
                ram[addr1] <= lat_wdata[15:8];
            end
            if (lat_funct3[1:0] == 2'b10) begin
                ram[addr2] <= lat_wdata[23:16];
                ram[addr3] <= lat_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed steps followed by random accesses, all
// compared against a byte-array reference model of the memory.
module tb_data_mem_responder;

    localparam int AW   = 17;
    localparam int LAT  = 2;
    localparam int MASK = (1 << AW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqWe = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddr = 32'h0;
    logic [31:0] reqWdata = 32'h0;
    logic        reqValid = 1'b0, reqValid0 = 1'b0;
    logic        respReady = 1'b1, respReady0 = 1'b1;
    logic        reqReady, reqReady0;
    logic        respValid, respValid0;
    logic [31:0] respRdata, respRdata0;
    logic        respErr, respErr0;

    int testCount = 0;
    int failCount = 0;

    // model[0] mirrors the LATENCY=2 instance, model[1] the LATENCY=0 instance.
    logic [7:0] model [2][1 << AW];

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid), .resp_ready(respReady),
        .resp_rdata(respRdata), .resp_err(respErr)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dutFast (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_ready(reqReady0), .req_we(reqWe),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid0), .resp_ready(respReady0),
        .resp_rdata(respRdata0), .resp_err(respErr0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: size from funct3, legality and alignment by plain arithmetic.
    task automatic modelAccess(input int sel, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] expData, output logic expErr);
        int size;
        bit legal;
        logic [31:0] val;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        expData = 32'h0;
        expErr  = 1'b0;
        if (!legal || (addr % size) != 0) begin
            expErr = 1'b1;
        end else if (we) begin
            for (int k = 0; k < size; k++) model[sel][(int'(addr) + k) & MASK] = wdata[8*k +: 8];
        end else begin
            val = 32'h0;
            for (int k = 0; k < size; k++) val = val + (32'(model[sel][(int'(addr) + k) & MASK]) << (8*k));
            if (!f3[2] && size == 1 && val[7])  val = val - 32'h100;
            if (!f3[2] && size == 2 && val[15]) val = val - 32'h10000;
            expData = val;
        end
    endtask

    task automatic applyStimulus(input bit fast, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold);
        logic [31:0] expData;
        logic        expErr;
        logic [31:0] heldData;
        int          cycles;
        modelAccess(fast ? 1 : 0, we, f3, addr, wdata, expData, expErr);
        checkOutput("req_ready_idle", fast ? reqReady0 : reqReady, 1);
        reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
        respReady  = (hold == 0);
        respReady0 = (hold == 0);
        if (fast) reqValid0 = 1'b1; else reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0; reqValid0 = 1'b0;
        reqWe = 1'($urandom); reqFunct3 = 3'($urandom); reqAddr = $urandom; reqWdata = $urandom;
        cycles = 0;
        while (!(fast ? respValid0 : respValid) && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("latency", cycles, (fast ? 0 : LAT) + 1);
        checkOutput("rdata", fast ? respRdata0 : respRdata, expData);
        checkOutput("err", fast ? respErr0 : respErr, expErr);
        heldData = fast ? respRdata0 : respRdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("held_valid", fast ? respValid0 : respValid, 1);
            checkOutput("held_rdata", fast ? respRdata0 : respRdata, heldData);
            checkOutput("held_req_ready", fast ? reqReady0 : reqReady, 0);
        end
        respReady = 1'b1; respReady0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("valid_drop", fast ? respValid0 : respValid, 0);
        checkOutput("req_ready_back", fast ? reqReady0 : reqReady, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_req_ready", reqReady, 1);
        checkOutput("reset_resp_valid", respValid, 0);
        checkOutput("reset_resp_rdata", respRdata, 0);
        checkOutput("reset_resp_err", respErr, 0);

        applyStimulus(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
        applyStimulus(0, 0, 3'b010, 32'h100, 32'h0, 0);
        applyStimulus(0, 0, 3'b000, 32'h100, 32'h0, 0);
        applyStimulus(0, 0, 3'b100, 32'h101, 32'h0, 0);
        applyStimulus(0, 0, 3'b001, 32'h102, 32'h0, 0);
        applyStimulus(0, 0, 3'b101, 32'h102, 32'h0, 0);
        applyStimulus(0, 1, 3'b000, 32'h101, 32'h12, 0);
        applyStimulus(0, 0, 3'b010, 32'h100, 32'h0, 0);
        applyStimulus(0, 1, 3'b001, 32'h103, 32'hFFFF, 0);
        applyStimulus(0, 0, 3'b010, 32'h100, 32'h0, 0);
        applyStimulus(0, 0, 3'b011, 32'h100, 32'h0, 0);
        applyStimulus(0, 1, 3'b100, 32'h104, 32'hAB, 0);
        applyStimulus(0, 0, 3'b010, 32'h20100, 32'h0, 5);

        applyStimulus(1, 1, 3'b010, 32'h40, 32'h0BADF00D, 0);
        applyStimulus(1, 0, 3'b100, 32'h41, 32'h0, 0);
        applyStimulus(1, 0, 3'b001, 32'h42, 32'h0, 0);

        // A reset one cycle into WAIT must abort the store before it commits.
        applyStimulus(0, 1, 3'b010, 32'h200, 32'h11223344, 0);
        reqWe = 1'b1; reqFunct3 = 3'b010; reqAddr = 32'h200; reqWdata = 32'h55AA55AA;
        reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_req_ready", reqReady, 1);
        checkOutput("abort_resp_valid", respValid, 0);
        checkOutput("abort_resp_rdata", respRdata, 0);
        checkOutput("abort_resp_err", respErr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 0, 3'b010, 32'h200, 32'h0, 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 3'b010, 32'h300 + 32'(4 * i), $urandom, 0);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1'($urandom), 3'($urandom),
                          (32'h300 + 32'($urandom_range(0, 63))) | ($urandom << AW),
                          $urandom, (i % 8 == 3) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
